vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator that replaces the fixed 640x480/25 MHz scan block. Every porch and sync width is a parameter, and sync polarity is per-axis. The pixel rate is an integer clock-enable divisor of the system clock rather than a derived clock. The block adds a run/stop control plus frame-start and line-end strobes. It sits between the system clock domain and the pixel/colour pipeline, and all downstream logic is qualified by `pix_ce`.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_pix_ce.sv | 45 ++++
 rtl/vga_timing_gen.sv | 160 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared video timing definitions.
//   - Default 640x480@60 raster constants (25 MHz pixel clock).
//   - Sync polarity constants and a helper mapping asserted/deasserted to a pin level.
//   - IDLE/RUN state type shared by raster-driven video blocks.
//   - Counter width helper that never returns zero.
package vga_pkg;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;
   localparam int unsigned VGA_CLK_DIV  = 4;

   localparam bit POL_ACTIVE_LOW  = 1'b0;
   localparam bit POL_ACTIVE_HIGH = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } vga_state_e;

   // Pin level for a sync signal given whether it is asserted and its polarity.
   function automatic logic sync_level(input logic asserted, input bit pol);
      return (pol == POL_ACTIVE_HIGH) ? asserted : ~asserted;
   endfunction

   // Bit width able to hold 0..n-1; at least 1 so a terminal count of 0 still has a register.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vga_pix_ce.sv
// vga_pix_ce: integer clock-enable divider.
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-low reset
//   pix_ce out one-clk pulse every CLK_DIV clocks; constant high when CLK_DIV=1
// The divider free-runs whenever reset is released.
module vga_pix_ce
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV = VGA_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   output logic pix_ce
);

   localparam int unsigned   CW   = cnt_width(CLK_DIV);
   localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

   if (CLK_DIV < 1) begin : g_chk_div
      $error("vga_pix_ce: CLK_DIV must be at least 1");
   end

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_ce;

   always_comb begin
      w_cnt_nxt = (r_cnt == TERM) ? '0 : r_cnt + CW'(1);
   end

   // The enable is registered from the next count so it is 0 in reset and
   // high exactly while the counter sits at its terminal value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_ce  <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_ce  <= (w_cnt_nxt == TERM);
      end
   end

   assign pix_ce = r_ce;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-low reset
//   en     in  run request; dropping it stops the raster at the next frame wrap
//   pix_ce out one-clk pulse per pixel period; other outputs change only on that edge
//   hsync  out horizontal sync, asserted level HS_POL
//   vsync  out vertical sync, asserted level VS_POL
//   de     out high in the visible region
//   x, y   out visible column/row, 0 outside the visible region
//   sof    out first pixel period of a frame
//   eol    out last pixel period of each line
// Line order (both axes): sync, back porch, active, front porch.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter bit          HS_POL   = POL_ACTIVE_LOW,
   parameter bit          VS_POL   = POL_ACTIVE_LOW,
   parameter int unsigned CLK_DIV  = VGA_CLK_DIV
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   output logic                        pix_ce,
   output logic                        hsync,
   output logic                        vsync,
   output logic                        de,
   output logic [$clog2(H_ACTIVE)-1:0] x,
   output logic [$clog2(V_ACTIVE)-1:0] y,
   output logic                        sof,
   output logic                        eol
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int unsigned HW      = cnt_width(H_TOTAL);
   localparam int unsigned VW      = cnt_width(V_TOTAL);
   localparam int unsigned XW      = $clog2(H_ACTIVE);
   localparam int unsigned YW      = $clog2(V_ACTIVE);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SE   = HW'(H_SYNC);
   localparam logic [HW-1:0] H_AS   = HW'(H_SYNC + H_BP);
   localparam logic [HW-1:0] H_AE   = HW'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SE   = VW'(V_SYNC);
   localparam logic [VW-1:0] V_AS   = VW'(V_SYNC + V_BP);
   localparam logic [VW-1:0] V_AE   = VW'(V_SYNC + V_BP + V_ACTIVE);

   localparam logic HS_IDLE = sync_level(1'b0, HS_POL);
   localparam logic VS_IDLE = sync_level(1'b0, VS_POL);

   if (CLK_DIV < 1) begin : g_chk_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end
   if (XW < 1 || YW < 1) begin : g_chk_width
      $error("vga_timing_gen: H_ACTIVE and V_ACTIVE must give x/y widths of at least 1");
   end

   logic          w_pix_ce;
   vga_state_e    r_state, w_state_nxt;
   logic [HW-1:0] r_h, w_h_nxt, w_hx;
   logic [VW-1:0] r_v, w_v_nxt, w_vy;
   logic          w_run, w_de;
   logic          r_hsync, r_vsync, r_de, r_sof, r_eol;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;

   vga_pix_ce #(.CLK_DIV(CLK_DIV)) u_pix_ce (
      .clk    (clk),
      .reset  (reset),
      .pix_ce (w_pix_ce)
   );

   // Next raster position and state; only a pixel enable can move them.
   always_comb begin
      w_state_nxt = r_state;
      w_h_nxt     = r_h;
      w_v_nxt     = r_v;
      if (w_pix_ce) begin
         case (r_state)
            ST_IDLE: begin
               if (en) begin
                  w_state_nxt = ST_RUN;
                  w_h_nxt     = '0;
                  w_v_nxt     = '0;
               end
            end
            ST_RUN: begin
               if (r_h == H_LAST) begin
                  w_h_nxt = '0;
                  if (r_v == V_LAST) begin
                     // Stop is honoured only at the frame wrap so a frame is never cut short.
                     w_v_nxt = '0;
                     if (!en) w_state_nxt = ST_IDLE;
                  end else begin
                     w_v_nxt = r_v + VW'(1);
                  end
               end else begin
                  w_h_nxt = r_h + HW'(1);
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next position so they describe the pixel
   // period that starts on the same edge, with no extra pixel of skew.
   always_comb begin
      w_run = (w_state_nxt == ST_RUN);
      w_de  = w_run && (w_h_nxt >= H_AS) && (w_h_nxt < H_AE)
                    && (w_v_nxt >= V_AS) && (w_v_nxt < V_AE);
      w_hx  = w_h_nxt - H_AS;
      w_vy  = w_v_nxt - V_AS;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_h     <= '0;
         r_v     <= '0;
         r_hsync <= HS_IDLE;
         r_vsync <= VS_IDLE;
         r_de    <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_sof   <= 1'b0;
         r_eol   <= 1'b0;
      end else if (w_pix_ce) begin
         r_state <= w_state_nxt;
         r_h     <= w_h_nxt;
         r_v     <= w_v_nxt;
         r_hsync <= sync_level(w_run && (w_h_nxt < H_SE), HS_POL);
         r_vsync <= sync_level(w_run && (w_v_nxt < V_SE), VS_POL);
         r_de    <= w_de;
         r_x     <= w_de ? w_hx[XW-1:0] : '0;
         r_y     <= w_de ? w_vy[YW-1:0] : '0;
         r_sof   <= w_run && (w_h_nxt == '0) && (w_v_nxt == '0);
         r_eol   <= w_run && (w_h_nxt == H_LAST);
      end
   end

   assign pix_ce = w_pix_ce;
   assign hsync  = r_hsync;
   assign vsync  = r_vsync;
   assign de     = r_de;
   assign x      = r_x;
   assign y      = r_y;
   assign sof    = r_sof;
   assign eol    = r_eol;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 15x8 raster (H 8/2/3/2, V 4/1/2/1).
// DUT A: CLK_DIV=2, active-low syncs. DUT B: CLK_DIV=1, active-high hsync.
// A cycle model pushes the expected output record per clock into a queue;
// monitors pop and compare on the falling edge. Directed checks cover the
// hand-computed frame statistics, stop/restart, and asynchronous reset.
module tb_vga_timing_gen;

   localparam int HA = 8, HF = 2, HS = 3, HB = 2;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = 15, VT = 8;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic en    = 1'b0;

   logic       a_ce, a_hs, a_vs, a_de, a_sof, a_eol;
   logic [2:0] a_x;
   logic [1:0] a_y;
   logic       b_ce, b_hs, b_vs, b_de, b_sof, b_eol;
   logic [2:0] b_x;
   logic [1:0] b_y;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2)
   ) dut_a (
      .clk(clk), .reset(reset), .en(en), .pix_ce(a_ce), .hsync(a_hs), .vsync(a_vs),
      .de(a_de), .x(a_x), .y(a_y), .sof(a_sof), .eol(a_eol)
   );

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(1)
   ) dut_b (
      .clk(clk), .reset(reset), .en(en), .pix_ce(b_ce), .hsync(b_hs), .vsync(b_vs),
      .de(b_de), .x(b_x), .y(b_y), .sof(b_sof), .eol(b_eol)
   );

   typedef struct packed {
      logic       ce, hs, vs, de;
      logic [2:0] x;
      logic [1:0] y;
      logic       sof, eol;
   } rec_t;

   typedef struct {
      int cnt;
      bit ce;
      bit run;
      int h;
      int v;
   } mdl_t;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.cnt = 0; m.ce = 1'b0; m.run = 1'b0; m.h = 0; m.v = 0;
      return m;
   endfunction

   // One system clock of the reference raster.
   function automatic mdl_t mdl_step(mdl_t m, bit e, int div);
      mdl_t n = m;
      if (m.ce) begin
         if (!m.run) begin
            if (e) begin n.run = 1'b1; n.h = 0; n.v = 0; end
         end else if (m.h == HT - 1) begin
            n.h = 0;
            if (m.v == VT - 1) begin
               n.v = 0;
               if (!e) n.run = 1'b0;
            end else n.v = m.v + 1;
         end else n.h = m.h + 1;
      end
      n.cnt = (m.cnt == div - 1) ? 0 : m.cnt + 1;
      n.ce  = (n.cnt == div - 1);
      return n;
   endfunction

   // Regions: h sync 0..2, bp 3..4, active 5..12, fp 13..14; v sync 0..1, bp 2, active 3..6, fp 7.
   function automatic rec_t expect_rec(mdl_t m, bit hpol);
      rec_t r = '0;
      r.ce = m.ce;
      if (!m.run) begin
         r.hs = ~hpol;
         r.vs = 1'b1;
      end else begin
         r.hs  = (m.h < 3) ? hpol : ~hpol;
         r.vs  = (m.v < 2) ? 1'b0 : 1'b1;
         r.de  = (m.h >= 5) && (m.h <= 12) && (m.v >= 3) && (m.v <= 6);
         r.x   = r.de ? 3'(m.h - 5) : 3'd0;
         r.y   = r.de ? 2'(m.v - 3) : 2'd0;
         r.sof = (m.h == 0) && (m.v == 0);
         r.eol = (m.h == 14);
      end
      return r;
   endfunction

   mdl_t ma, mb;
   rec_t qa[$], qb[$];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         ma <= mdl_reset();
         mb <= mdl_reset();
         qa.delete();
         qb.delete();
         qa.push_back(expect_rec(mdl_reset(), 1'b0));
         qb.push_back(expect_rec(mdl_reset(), 1'b1));
      end else begin
         ma <= mdl_step(ma, en, 2);
         mb <= mdl_step(mb, en, 1);
         qa.push_back(expect_rec(mdl_step(ma, en, 2), 1'b0));
         qb.push_back(expect_rec(mdl_step(mb, en, 1), 1'b1));
      end
   end

   int nprint = 0;

   always @(negedge clk) begin
      rec_t ea, eb, ra, rb;
      ra = {a_ce, a_hs, a_vs, a_de, a_x, a_y, a_sof, a_eol};
      rb = {b_ce, b_hs, b_vs, b_de, b_x, b_y, b_sof, b_eol};
      total = total + 2;
      if (qa.size() == 0 || qb.size() == 0) begin
         bad = bad + 2;
         $display("FAIL sb_empty t=%0t got qa=%0d qb=%0d entries, expected 1 each", $time, qa.size(), qb.size());
      end else begin
         ea = qa.pop_front();
         eb = qb.pop_front();
         if (ra !== ea) begin
            bad++;
            if (nprint < 40) $display("FAIL sb_a t=%0t got=%h expected=%h", $time, ra, ea);
            nprint++;
         end
         if (rb !== eb) begin
            bad++;
            if (nprint < 40) $display("FAIL sb_b t=%0t got=%h expected=%h", $time, rb, eb);
            nprint++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ce"},  {31'd0, a_ce},  0);
      check({tag, "_hs"},  {31'd0, a_hs},  1);
      check({tag, "_vs"},  {31'd0, a_vs},  1);
      check({tag, "_de"},  {31'd0, a_de},  0);
      check({tag, "_x"},   {29'd0, a_x},   0);
      check({tag, "_y"},   {30'd0, a_y},   0);
      check({tag, "_sof"}, {31'd0, a_sof}, 0);
      check({tag, "_eol"}, {31'd0, a_eol}, 0);
      check({tag, "_b_hs"}, {31'd0, b_hs}, 0);
      check({tag, "_b_ce"}, {31'd0, b_ce}, 0);
   endtask

   // Called right after reset release (posedge+2); counts clocks to the first sof.
   task automatic check_sof_latency(input string tag);
      int lat = 0;
      bit got = 1'b0;
      while (lat < 10 && !got) begin
         @(posedge clk); #1;
         lat++;
         got = a_sof;
      end
      check({tag, "_sof_seen"}, {31'd0, got}, 1);
      check({tag, "_sof_le_2clk"}, {31'd0, (lat <= 2)}, 1);
   endtask

   // Sampling at posedge+1: clocks until the next rising edge of sof, limit 1000.
   task automatic clocks_to_sof(output int clks, output bit found);
      bit prev = a_sof;
      clks  = 0;
      found = 1'b0;
      while (clks < 1000 && !found) begin
         @(posedge clk); #1;
         clks++;
         if (a_sof && !prev) found = 1'b1;
         prev = a_sof;
      end
   endtask

   initial begin
      int clks, de_n, hsl_n, vsl_n, bce_low, mx, my, n, sof_n, eol_n;
      bit found, p_sof, p_eol;

      reset = 1'b0;
      en    = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("rst0");

      @(posedge clk); #2 reset = 1'b1;
      check_sof_latency("start");

      // One full frame from the first sof.
      clks = 0; de_n = 0; hsl_n = 0; vsl_n = 0; bce_low = 0; mx = 0; my = 0;
      found = 1'b0; p_sof = 1'b1;
      while (clks < 1000 && !found) begin
         @(posedge clk); #1;
         clks++;
         if (!b_ce) bce_low++;
         if (a_ce) begin
            if (a_de) begin
               de_n++;
               if (int'(a_x) > mx) mx = int'(a_x);
               if (int'(a_y) > my) my = int'(a_y);
            end
            if (!a_hs) hsl_n++;
            if (!a_vs) vsl_n++;
         end
         if (a_sof && !p_sof) found = 1'b1;
         p_sof = a_sof;
      end
      check("frame_found",     {31'd0, found}, 1);
      check("frame_period",    clks,    240);
      check("de_periods",      de_n,    32);
      check("x_max",           mx,      7);
      check("y_max",           my,      3);
      check("hsync_low_per",   hsl_n,   24);
      check("vsync_low_per",   vsl_n,   30);
      check("b_ce_low_clocks", bce_low, 0);

      // Drop en at (h=4, v=5): the frame must finish, then the raster idles.
      n = 0; clks = 0;
      while (n < 79 && clks < 400) begin
         @(posedge clk); #1;
         clks++;
         if (a_ce) n++;
      end
      @(posedge clk); #1;
      en = 1'b0;
      sof_n = 0; eol_n = 0; p_sof = a_sof; p_eol = a_eol;
      repeat (300) begin
         @(posedge clk); #1;
         if (a_sof && !p_sof) sof_n++;
         if (a_eol && !p_eol) eol_n++;
         p_sof = a_sof;
         p_eol = a_eol;
      end
      check("stop_sof_count", sof_n, 0);
      check("stop_eol_count", eol_n, 3);
      check("idle_hs",  {31'd0, a_hs}, 1);
      check("idle_vs",  {31'd0, a_vs}, 1);
      check("idle_de",  {31'd0, a_de}, 0);
      check("idle_sof", {31'd0, a_sof}, 0);

      // Restart, then glitch en low mid-frame: no gap between frames.
      en = 1'b1;
      clocks_to_sof(clks, found);
      check("restart_sof", {31'd0, found}, 1);
      check("restart_lat_le_4", {31'd0, (clks <= 4)}, 1);
      fork
         begin
            repeat (60) @(posedge clk);
            #1 en = 1'b0;
            repeat (30) @(posedge clk);
            #1 en = 1'b1;
         end
         clocks_to_sof(clks, found);
      join
      check("glitch_sof",    {31'd0, found}, 1);
      check("glitch_period", clks, 240);

      // Asynchronous reset while x=3 is on screen.
      found = 1'b0; clks = 0;
      while (!found && clks < 400) begin
         @(posedge clk); #1;
         clks++;
         found = a_de && (a_x == 3'd3);
      end
      check("x3_found", {31'd0, found}, 1);
      #3 reset = 1'b0;
      #1 check_reset_outputs("rst_async");
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      check_sof_latency("rerun");

      repeat (50) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
